// File: rtl/div_unit_pkg.sv
// Shared types for the iterative RV32M-style divider: operation encodings,
// controller states and small decode helpers for the op field.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

    // REM/REMU return the remainder, DIV/DIVU the quotient
    function automatic logic isRemOp(input div_op_e opIn);
        return opIn[1];
    endfunction

    // DIV/REM treat operands as two's complement
    function automatic logic isSignedOp(input div_op_e opIn);
        return ~opIn[0];
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// The quotient register initially holds the dividend; each iteration shifts
// its MSB into the partial remainder and the new quotient bit in at the LSB.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial-subtract the divisor; a borrow means restore the shifted remainder
    always_comb begin
        shifted = {remIn, quoIn[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[WIDTH]) begin
            remOut = shifted[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b0};
        end else begin
            remOut = trial[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative WIDTH-bit divider for DIV/DIVU/REM/REMU, one quotient bit per
// clock. Optional macro DIV_FAST_PATH_EN: divide-by-zero and signed overflow
// skip the iteration and finish on the accepting edge. Results are identical
// in both builds because those cases always take a precomputed value.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_e       state_q, state_d;
    div_op_e          op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisorMag_q, divisorMag_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] specialRes_q, specialRes_d;
    logic             negQuo_q, negQuo_d;
    logic             negRem_q, negRem_d;
    logic             special_q, special_d;

    div_op_e          opIn;
    logic             signedIn;
    logic             dividendNeg;
    logic             divisorNeg;
    logic [WIDTH-1:0] dividendMag;
    logic [WIDTH-1:0] divisorMag;
    logic             divZero;
    logic             overflow;
    logic [WIDTH-1:0] specialVal;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;
    logic [WIDTH-1:0] quoSigned;
    logic [WIDTH-1:0] remSigned;
    logic [WIDTH-1:0] finalRes;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .remIn   (rem_q),
        .quoIn   (quo_q),
        .divisor (divisorMag_q),
        .remOut  (stepRem),
        .quoOut  (stepQuo)
    );

    // Decode incoming operands: signs, magnitudes and the two corner cases
    always_comb begin
        opIn        = div_op_e'(op);
        signedIn    = isSignedOp(opIn);
        dividendNeg = signedIn & dividend[WIDTH-1];
        divisorNeg  = signedIn & divisor[WIDTH-1];
        dividendMag = dividendNeg ? -dividend : dividend;
        divisorMag  = divisorNeg ? -divisor : divisor;
        divZero     = (divisor == '0);
        overflow    = signedIn && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                      && (divisor == '1);
        if (divZero) begin
            specialVal = isRemOp(opIn) ? dividend : '1;
        end else begin
            specialVal = isRemOp(opIn) ? '0 : dividend;
        end
    end

    // Apply signs to the last step's outputs and pick quotient or remainder
    always_comb begin
        quoSigned = negQuo_q ? -stepQuo : stepQuo;
        remSigned = negRem_q ? -stepRem : stepRem;
        if (special_q) begin
            finalRes = specialRes_q;
        end else begin
            finalRes = isRemOp(op_q) ? remSigned : quoSigned;
        end
    end

    // Controller next state and datapath loads for IDLE -> CALC -> DONE
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        count_d      = count_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        divisorMag_d = divisorMag_q;
        result_d     = result_q;
        specialRes_d = specialRes_q;
        negQuo_d     = negQuo_q;
        negRem_d     = negRem_q;
        special_d    = special_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d         = opIn;
                    rem_d        = '0;
                    quo_d        = dividendMag;
                    divisorMag_d = divisorMag;
                    negQuo_d     = dividendNeg ^ divisorNeg;
                    negRem_d     = dividendNeg;
                    special_d    = divZero | overflow;
                    specialRes_d = specialVal;
                    count_d      = CW'(WIDTH - 1);
`ifdef DIV_FAST_PATH_EN
                    if (divZero || overflow) begin
                        state_d  = DONE;
                        result_d = specialVal;
                    end else begin
                        state_d  = CALC;
                    end
`else
                    state_d      = CALC;
`endif
                end
            end
            CALC: begin
                rem_d = stepRem;
                quo_d = stepQuo;
                if (count_q == '0) begin
                    state_d  = DONE;
                    result_d = finalRes;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= DIV_OP_DIV;
            count_q      <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            divisorMag_q <= '0;
            result_q     <= '0;
            specialRes_q <= '0;
            negQuo_q     <= 1'b0;
            negRem_q     <= 1'b0;
            special_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            count_q      <= count_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            divisorMag_q <= divisorMag_d;
            result_q     <= result_d;
            specialRes_q <= specialRes_d;
            negQuo_q     <= negQuo_d;
            negRem_q     <= negRem_d;
            special_q    <= special_d;
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH = 32). Latency is counted
// as rising edges from the accepting edge up to the edge after which done is
// seen, so a normal operation takes WIDTH+1 and the fast path takes 1.
module tb_div_unit;

    localparam int WIDTH    = 32;
    localparam int FULL_LAT = WIDTH + 1;
`ifdef DIV_FAST_PATH_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = FULL_LAT;
`endif

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int checkCount;
    int errorCount;

    div_unit #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one operation, wait (bounded) for done, then confirm done drops
    task automatic applyStimulus(input logic [1:0] opIn, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 output logic [WIDTH-1:0] res, output int lat);
        bit seen;
        @(negedge clk);
        start    = 1'b1;
        op       = opIn;
        dividend = a;
        divisor  = b;
        lat      = 0;
        seen     = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (done) seen = 1'b1;
        end
        if (!seen) checkOutput("timeout", 32'd0, 32'd1);
        res = result;
        @(posedge clk);
        #1;
        checkOutput("donePulseWidth", {31'd0, done}, 32'd0);
    endtask

    task automatic runVector(input string tag, input logic [1:0] opIn,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] expRes, input int expLat);
        logic [WIDTH-1:0] res;
        int lat;
        applyStimulus(opIn, a, b, res, lat);
        checkOutput({tag, "_result"}, res, expRes);
        checkOutput({tag, "_latency"}, lat, expLat);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [WIDTH-1:0] lastRes;

        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        op         = 2'b00;
        dividend   = '0;
        divisor    = '0;

        #12;
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetResult", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runVector("divu100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resultHold", result, 32'd14);
        runVector("remu100_7", OP_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT);

        runVector("divNeg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT);
        runVector("remNeg7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FULL_LAT);
        runVector("div7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL_LAT);
        runVector("rem7_neg2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, FULL_LAT);

        runVector("divuByZero", OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        runVector("remuByZero", OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, SPECIAL_LAT);
        runVector("divNegByZero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        runVector("remNegByZero", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPECIAL_LAT);

        runVector("divOverflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
        runVector("remOverflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_LAT);
        runVector("divuMinByOnes", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FULL_LAT);

        // A second start during CALC must be dropped, giving one done pulse
        @(negedge clk);
        start    = 1'b1;
        op       = OP_DIVU;
        dividend = 32'd100;
        divisor  = 32'd7;
        pulses   = 0;
        lastRes  = '0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i == 5) begin
                checkOutput("midCalcBusy", {31'd0, busy}, 32'd1);
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end
            if (done) begin
                pulses++;
                lastRes = result;
            end
        end
        checkOutput("ignoredStartPulses", pulses, 32'd1);
        checkOutput("ignoredStartResult", lastRes, 32'd14);

        // Reset 10 cycles into CALC aborts without a done pulse
        @(negedge clk);
        start    = 1'b1;
        op       = OP_DIVU;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        checkOutput("abortResult", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("abortNoDone", pulses, 32'd0);
        runVector("divu9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, FULL_LAT);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
